// File: rtl/cpu_control_fsm_pkg.sv
// Shared types for the multicycle RV32I main controller: state encoding,
// ALU command and operation classes, opcodes and datapath select encodings.
package cpu_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } cpu_state_t;

    // Command to the ALU itself
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_opcode_t;

    // Operation class chosen by the FSM, refined by the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_MEMDAT = 2'b01,
        RES_ALU    = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC     = 2'b00,
        SRCA_OLDPC  = 2'b01,
        SRCA_RS1    = 2'b10
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2    = 2'b00,
        SRCB_IMM    = 2'b01,
        SRCB_FOUR   = 2'b10
    } alu_src_b_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011
    } imm_src_t;

    // Immediate format follows the opcode alone; unknown opcodes fall back to I
    function automatic imm_src_t imm_for_opcode(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_ITYPE: return IMM_I;
            OP_STORE:          return IMM_S;
            OP_BRANCH:         return IMM_B;
            OP_JAL:            return IMM_J;
            default:           return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/cpu_control_fsm_alu_decoder.sv
// ALU command decoder: turns the FSM's operation class plus funct fields
// into the concrete ALU opcode.
module cpu_alu_decoder
    import cpu_control_fsm_pkg::*;
(
    input  alu_op_t     alu_op,
    input  logic [2:0]  funct3,
    input  logic        funct7_b5,
    input  logic        opcode_b5,
    output alu_opcode_t alu_control
);

    // funct decode; SUB only for R-type (opcode[5]) with funct7[5] set
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (funct7_b5 & opcode_b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multicycle main controller: sequences fetch, decode, execute, memory and
// writeback over a shared datapath with a single memory port.
module cpu_control_fsm
    import cpu_control_fsm_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter bit MEM_WAIT_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal_instr
);

    cpu_state_t  state_reg;
    cpu_state_t  state_next;
    alu_op_t     alu_op;
    alu_opcode_t alu_cmd;
    logic        mem_ok;
    logic        branch_taken;

    assign mem_ok = MEM_WAIT_EN ? mem_ready : 1'b1;

    assign branch_taken = ((funct3 == 3'b000) &  alu_zero) |
                          ((funct3 == 3'b001) & ~alu_zero);

    cpu_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_b5   (funct7_b5),
        .opcode_b5   (opcode[5]),
        .alu_control (alu_cmd)
    );

    // State register; reset always restarts at FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:    state_next = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_JAL:            state_next = S_JAL;
                    OP_BRANCH:         state_next = S_BRANCH;
                    default:           state_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = mem_ok ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = mem_ok ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_BRANCH:   state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    // Output decode; reset forces every enable and select to its idle value
    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        imm_src       = IMM_I;
        alu_op        = ALUOP_ADD;
        illegal_instr = 1'b0;
        if (!rst) begin
            imm_src = imm_for_opcode(opcode);
            case (state_reg)
                S_FETCH: begin
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    ir_write   = mem_ok;
                    pc_write   = mem_ok;
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMREAD: begin
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    result_src = RES_MEMDAT;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_FUNCT;
                end
                S_EXECI: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                end
                S_JAL: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_FOUR;
                    pc_write  = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_SUB;
                    pc_write  = branch_taken;
                end
                S_TRAP: begin
                    illegal_instr = 1'b1;
                end
                default: begin
                    illegal_instr = 1'b0;
                end
            endcase
        end
    end

    assign alu_control = rst ? ALU_ADD : alu_cmd;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for the multicycle controller: each instruction is expanded into an
// expected per-cycle trace (inputs to drive plus required outputs) and the
// DUT is compared against it every cycle.
module tb_cpu_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_b5 = 1'b0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, ir_write, adr_src, mem_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src, alu_control;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .funct7_b5(funct7_b5), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
        .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_control(alu_control), .illegal_instr(illegal_instr)
    );

    // {pc, ir, adr, mw, rw, rs[2], a[2], b[2], imm[3], alu[3], ill}
    typedef struct {
        logic        mr;
        logic        zero;
        logic [17:0] exp;
        string       tag;
    } step_t;

    function automatic logic [17:0] observed();
        return {pc_write, ir_write, adr_src, mem_write, reg_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr};
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0010011: return 3'b000;
            7'b0100011:             return 3'b001;
            7'b1100011:             return 3'b010;
            7'b1101111:             return 3'b011;
            default:                return 3'b000;
        endcase
    endfunction

    // Arithmetic command for R/I execution from funct fields
    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic f7, input logic [6:0] op);
        case (f3)
            3'b000:  return (f7 && op[5]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic step_t mk(input logic mr, input logic pc, input logic ir,
                                 input logic adr, input logic mw, input logic rw,
                                 input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                                 input logic [2:0] imm, input logic [2:0] alu, input logic ill,
                                 input string tag);
        step_t s;
        s.mr   = mr;
        s.zero = 1'($urandom_range(0, 1));
        s.exp  = {pc, ir, adr, mw, rw, rs, a, b, imm, alu, ill};
        s.tag  = tag;
        return s;
    endfunction

    task automatic check_vec(input string tag, input logic [17:0] exp);
        logic [17:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b required=%b (pc ir adr mw rw rs a b imm alu ill)", tag, obs, exp);
        end
    endtask

    task automatic reset_cycles(input int n, input logic [6:0] op);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            opcode = op;
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            check_vec("reset_idle", 18'd0);
        end
    endtask

    // Expand one instruction into its expected trace and play it.
    // abort_at >= 0 applies reset at that cycle of the instruction.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input int wf, input int wm, input int abort_at, input logic bz);
        step_t q[$];
        step_t s;
        logic [2:0] im;
        int n;
        logic bad;
        im = imm_of(op);
        bad = 1'b0;
        for (int i = 0; i < wf; i++) q.push_back(mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, im, 3'b000, 0, "fetch_wait"));
        q.push_back(mk(1, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, im, 3'b000, 0, "fetch"));
        q.push_back(mk(1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 3'b000, 0, "decode"));
        case (op)
            7'b0000011: begin
                q.push_back(mk(1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 3'b000, 0, "lw_addr"));
                for (int i = 0; i < wm; i++) q.push_back(mk(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, "lw_wait"));
                q.push_back(mk(1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, "lw_read"));
                q.push_back(mk(1'($urandom_range(0, 1)), 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, im, 3'b000, 0, "lw_wb"));
            end
            7'b0100011: begin
                q.push_back(mk(1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 3'b000, 0, "sw_addr"));
                for (int i = 0; i < wm; i++) q.push_back(mk(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, "sw_wait"));
                q.push_back(mk(1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, "sw_write"));
            end
            7'b0110011, 7'b0010011: begin
                q.push_back(mk(1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 2'b00, 2'b10,
                               op[5] ? 2'b00 : 2'b01, im, alu_of(f3, f7, op), 0, "alu_exec"));
                q.push_back(mk(1'($urandom_range(0, 1)), 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, "alu_wb"));
            end
            7'b1101111: begin
                q.push_back(mk(1'($urandom_range(0, 1)), 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, 3'b000, 0, "jal_target"));
                q.push_back(mk(1'($urandom_range(0, 1)), 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, "jal_link"));
            end
            7'b1100011: begin
                s = mk(1'($urandom_range(0, 1)),
                       ((f3 == 3'b000) && bz) || ((f3 == 3'b001) && !bz),
                       0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, 3'b001, 0, "branch");
                s.zero = bz;
                q.push_back(s);
            end
            default: begin
                bad = 1'b1;
                for (int i = 0; i < 10; i++)
                    q.push_back(mk(1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 1, "trap_hold"));
            end
        endcase
        n = 0;
        foreach (q[i]) begin
            if (i == abort_at) break;
            @(negedge clk);
            rst = 1'b0;
            opcode = op;
            funct3 = f3;
            funct7_b5 = f7;
            mem_ready = q[i].mr;
            alu_zero = q[i].zero;
            #1;
            check_vec(q[i].tag, q[i].exp);
            n++;
        end
        if (bad || abort_at >= 0) reset_cycles(1, op);
        $display("instr op=%b f3=%b f7=%b wf=%0d wm=%0d cycles=%0d%s", op, f3, f7, wf, wm, n,
                 (abort_at >= 0) ? " aborted" : (bad ? " trapped" : ""));
    endtask

    initial begin
        logic [6:0] ops [6];
        logic [6:0] op;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1101111; ops[5] = 7'b1100011;

        reset_cycles(2, 7'b0110011);
        run_instr(7'b0110011, 3'b000, 1'b1, 0, 0, -1, 1'b0);   // sub, 4 cycles
        run_instr(7'b0000011, 3'b010, 1'b0, 0, 2, -1, 1'b0);   // lw, 2 waits -> 7
        run_instr(7'b0100011, 3'b010, 1'b0, 0, 1, -1, 1'b0);   // sw, 1 wait
        run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, -1, 1'b1);   // beq taken
        run_instr(7'b1100011, 3'b001, 1'b0, 0, 0, -1, 1'b1);   // bne not taken
        run_instr(7'b1101111, 3'b000, 1'b0, 1, 0, -1, 1'b0);   // jal, fetch wait
        run_instr(7'b0010011, 3'b000, 1'b1, 0, 0, -1, 1'b0);   // addi with f7 set stays ADD

        for (int k = 0; k < 40; k++) begin
            op = ops[$urandom_range(0, 5)];
            run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 2), -1, 1'($urandom_range(0, 1)));
        end

        run_instr(7'b0000011, 3'b010, 1'b0, 0, 3, 4, 1'b0);    // reset mid-load
        run_instr(7'b0110011, 3'b111, 1'b0, 0, 0, -1, 1'b0);   // and after abort
        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, -1, 1'b0);   // illegal -> trap
        run_instr(7'b0110011, 3'b110, 1'b0, 0, 0, -1, 1'b0);   // or after trap reset

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
